// File: rtl/pipeline_decode_pkg.sv
// Shared decode definitions for the pipeline_decode slice: opcode/funct
// values, early-branch command encodings, stall widths, and a helper that
// splits a 32-bit MIPS-style instruction into the fields decode needs.
// Optional build macro used elsewhere in this slice: MULDIV_HAZARD_EN.
package pipeline_pkg;

    localparam int STALL_W = 2;
    localparam int EBC_W   = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] LB    = 6'h20;
    localparam logic [5:0] LBU   = 6'h24;
    localparam logic [5:0] LH    = 6'h21;
    localparam logic [5:0] LHU   = 6'h25;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] SB    = 6'h28;
    localparam logic [5:0] SH    = 6'h29;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] JAL   = 6'h03;
    localparam logic [5:0] ANDI  = 6'h0C;
    localparam logic [5:0] ORI   = 6'h0D;
    localparam logic [5:0] XORI  = 6'h0E;

    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;
    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MFLO  = 6'h12;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [EBC_W-1:0] {
        EBC_NONE = 4'd0,
        EBC_J    = 4'd1,
        EBC_JAL  = 4'd2
    } ebc_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_j;
        logic        is_jal;
        logic        rs_read;
        logic        rt_read;
        logic        hilo_write;
        logic        hilo_read;
    } decoded_t;

    // rt is only a source for R-type, stores and the two compare branches;
    // for other I-type formats it is the destination.
    function automatic decoded_t decode_inst(input logic [31:0] inst);
        decoded_t   d;
        logic [5:0] op;
        logic [5:0] fn;
        op = inst[31:26];
        fn = inst[5:0];
        d = '0;
        d.rs         = inst[25:21];
        d.rt         = inst[20:16];
        d.is_load    = op inside {LW, LB, LBU, LH, LHU};
        d.is_store   = op inside {SW, SB, SH};
        d.is_j       = (op == J);
        d.is_jal     = (op == JAL);
        d.is_branch  = (op == BEQ) || (op == BNE) || d.is_j || d.is_jal;
        d.rs_read    = !(d.is_j || d.is_jal);
        d.rt_read    = (op == OP_RTYPE) || d.is_store || (op == BEQ) || (op == BNE);
        d.hilo_write = (op == OP_RTYPE) && (fn inside {MULT, MULTU, DIV, DIVU});
        d.hilo_read  = (op == OP_RTYPE) && (fn inside {MFHI, MFLO});
        if (op inside {ANDI, ORI, XORI})
            d.imm = {16'h0000, inst[15:0]};
        else
            d.imm = {{16{inst[15]}}, inst[15:0]};
        if (op == OP_RTYPE)
            d.dest = inst[15:11];
        else if (d.is_jal)
            d.dest = LINK_REG;
        else if (d.is_store || d.is_branch)
            d.dest = 5'd0;
        else
            d.dest = inst[20:16];
        return d;
    endfunction

endpackage

// File: rtl/pipeline_decode_if.sv
// Bus between fetch (master side) and decode (slave side): the fetched
// pc/inst and flush coming in, stall/early-branch feedback and the
// registered decode bundle for the ALU going out.
interface pipeline_decode_if;
    import pipeline_pkg::*;

    logic [31:0]        pc_in;
    logic [31:0]        inst_in;
    logic               late_flush;
    logic [STALL_W-1:0] stall_request;
    logic [EBC_W-1:0]   early_branch_cmd;
    logic               d_valid;
    logic [31:0]        d_pc;
    logic [31:0]        d_inst;
    logic [4:0]         d_rs;
    logic [4:0]         d_rt;
    logic [4:0]         d_dest;
    logic [31:0]        d_imm;
    logic               d_is_load;
    logic               d_is_store;
    logic               d_is_branch;

    modport master (
        output pc_in, inst_in, late_flush,
        input  stall_request, early_branch_cmd, d_valid, d_pc, d_inst,
               d_rs, d_rt, d_dest, d_imm, d_is_load, d_is_store, d_is_branch
    );

    modport slave (
        input  pc_in, inst_in, late_flush,
        output stall_request, early_branch_cmd, d_valid, d_pc, d_inst,
               d_rs, d_rt, d_dest, d_imm, d_is_load, d_is_store, d_is_branch
    );

endinterface

// File: rtl/pipeline_decode_hazard.sv
// Hazard tracking for decode: load-use scoreboard, stall countdown that
// mirrors fetch, and (with MULDIV_HAZARD_EN) HI/LO result age tracking.
// Produces the stall request to fetch and the issue decision for decode.
module decode_hazard
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    input  logic [4:0]         dest,
    input  logic               rs_read,
    input  logic               rt_read,
    input  logic               is_load,
    input  logic               hilo_write,
    input  logic               hilo_read,
    input  logic               late_flush,
    output logic [STALL_W-1:0] stall_request,
    output logic               hazard,
    output logic               issue
);

    logic [4:0]         prev_load_dest;
    logic [STALL_W-1:0] stall_cnt;
    logic               first_cycle;
    logic               load_hazard;
    logic               hilo_hazard;
    logic               stall_busy;
    logic [STALL_W-1:0] req_raw;

`ifdef MULDIV_HAZARD_EN
    logic [STALL_W-1:0] hilo_age;

    // Age of the newest HI/LO writer: set when it issues, then counts down.
    always_ff @(posedge clk) begin
        if (rst || late_flush)
            hilo_age <= '0;
        else if (issue && hilo_write)
            hilo_age <= STALL_W'(2);
        else if (hilo_age != '0)
            hilo_age <= hilo_age - STALL_W'(1);
    end

    assign hilo_hazard = inst_valid && hilo_read && (hilo_age != '0);
    assign req_raw     = hilo_hazard ? hilo_age : STALL_W'(1);
`else
    logic unused_hilo;
    assign unused_hilo = hilo_write ^ hilo_read;
    assign hilo_hazard = 1'b0;
    assign req_raw     = STALL_W'(1);
`endif

    // Register 0 is excluded by requiring a nonzero scoreboard entry.
    assign load_hazard = inst_valid && (prev_load_dest != 5'd0) &&
                         ((rs_read && (rs == prev_load_dest)) ||
                          (rt_read && (rt == prev_load_dest)));

    assign hazard        = (load_hazard || hilo_hazard) && !late_flush && !rst;
    assign stall_busy    = (stall_cnt != '0);
    assign issue         = inst_valid && !hazard && !late_flush && !stall_busy && !rst;
    assign stall_request = (hazard && !stall_busy && !first_cycle) ? req_raw : '0;

    // Scoreboard, stall countdown and first-cycle marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_load_dest <= 5'd0;
            stall_cnt      <= '0;
            first_cycle    <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
            if (late_flush) begin
                prev_load_dest <= 5'd0;
                stall_cnt      <= '0;
            end else begin
                prev_load_dest <= (issue && is_load) ? dest : 5'd0;
                if (stall_request != '0)
                    stall_cnt <= stall_request - STALL_W'(1);
                else if (stall_busy)
                    stall_cnt <= stall_cnt - STALL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_decode.sv
// DECODE stage: decodes fetch's pc/inst, registers the bundle for the ALU,
// requests stalls on load-use (and, with MULDIV_HAZARD_EN, HI/LO) hazards,
// and issues early redirects for J/JAL. late_flush squashes the stage.
module pipeline_decode
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    pipeline_decode_if.slave bus
);

    decoded_t dec;
    logic     inst_valid;
    logic     hazard;
    logic     issue;
    ebc_t     ebc;

    assign dec        = decode_inst(bus.inst_in);
    assign inst_valid = (bus.inst_in != 32'h0);

    decode_hazard u_hazard (
        .clk           (clk),
        .rst           (rst),
        .inst_valid    (inst_valid),
        .rs            (dec.rs),
        .rt            (dec.rt),
        .dest          (dec.dest),
        .rs_read       (dec.rs_read),
        .rt_read       (dec.rt_read),
        .is_load       (dec.is_load),
        .hilo_write    (dec.hilo_write),
        .hilo_read     (dec.hilo_read),
        .late_flush    (bus.late_flush),
        .stall_request (bus.stall_request),
        .hazard        (hazard),
        .issue         (issue)
    );

    // Early redirect only when the jump actually issues this cycle.
    always_comb begin
        ebc = EBC_NONE;
        if (issue && dec.is_jal)
            ebc = EBC_JAL;
        else if (issue && dec.is_j)
            ebc = EBC_J;
    end

    assign bus.early_branch_cmd = ebc;

    // Decoded bundle register; anything not issuing becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            bus.d_valid     <= 1'b0;
            bus.d_pc        <= RESET_PC;
            bus.d_inst      <= 32'h0;
            bus.d_rs        <= 5'd0;
            bus.d_rt        <= 5'd0;
            bus.d_dest      <= 5'd0;
            bus.d_imm       <= 32'h0;
            bus.d_is_load   <= 1'b0;
            bus.d_is_store  <= 1'b0;
            bus.d_is_branch <= 1'b0;
        end else begin
            bus.d_valid     <= 1'b1;
            bus.d_pc        <= bus.pc_in;
            bus.d_inst      <= bus.inst_in;
            bus.d_rs        <= dec.rs;
            bus.d_rt        <= dec.rt;
            bus.d_dest      <= dec.dest;
            bus.d_imm       <= dec.imm;
            bus.d_is_load   <= dec.is_load;
            bus.d_is_store  <= dec.is_store;
            bus.d_is_branch <= dec.is_branch;
        end
    end

endmodule

// File: tb/tb_pipeline_decode.sv
// Directed bench for pipeline_decode: the bench plays fetch, drives one
// instruction per cycle and compares combinational feedback before the
// edge and the registered bundle just after it. Build with
// MULDIV_HAZARD_EN defined to exercise the HI/LO stall path.
module tb_pipeline_decode;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0400;

    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_LW_T0    = 32'h8D28_0000;
    localparam logic [31:0] I_ADD_T2   = 32'h0108_5020;
    localparam logic [31:0] I_J        = 32'h0800_0040;
    localparam logic [31:0] I_JAL      = 32'h0C00_0040;
    localparam logic [31:0] I_ORI      = 32'h3408_8000;
    localparam logic [31:0] I_ADDI     = 32'h2008_FFFF;
    localparam logic [31:0] I_LW_ZERO  = 32'h8D20_0000;
    localparam logic [31:0] I_ADD_ZERO = 32'h0000_5020;
    localparam logic [31:0] I_SW_T0    = 32'hAD28_0000;
    localparam logic [31:0] I_ORI_T0   = 32'h3408_0001;
    localparam logic [31:0] I_MULT     = 32'h0109_0018;
    localparam logic [31:0] I_MFLO     = 32'h0000_5012;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipeline_decode_if bus_if ();

    pipeline_decode #(.RESET_PC(TB_RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one fetch slot shortly after the falling edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst,
                                 input logic flush, input logic reset);
        @(negedge clk);
        bus_if.pc_in      = pc;
        bus_if.inst_in    = inst;
        bus_if.late_flush = flush;
        rst               = reset;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkComb(input string tag, input logic [1:0] stall,
                             input logic [3:0] ebc);
        checkOutput({tag, ".stall"}, 32'(bus_if.stall_request), 32'(stall));
        checkOutput({tag, ".ebc"}, 32'(bus_if.early_branch_cmd), 32'(ebc));
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, ".d_valid"}, 32'(bus_if.d_valid), 32'd0);
        checkOutput({tag, ".d_inst"}, bus_if.d_inst, 32'h0);
        checkOutput({tag, ".d_pc"}, bus_if.d_pc, TB_RESET_PC);
    endtask

    task automatic checkIssued(input string tag, input logic [31:0] pc,
                               input logic [31:0] inst, input logic [4:0] dest);
        checkOutput({tag, ".d_valid"}, 32'(bus_if.d_valid), 32'd1);
        checkOutput({tag, ".d_pc"}, bus_if.d_pc, pc);
        checkOutput({tag, ".d_inst"}, bus_if.d_inst, inst);
        checkOutput({tag, ".d_dest"}, 32'(bus_if.d_dest), 32'(dest));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.pc_in      = 32'h0;
        bus_if.inst_in    = I_NOP;
        bus_if.late_flush = 1'b0;

        // Reset state
        tick();
        tick();
        checkBubble("reset");
        checkComb("reset", 2'd0, 4'd0);
        checkOutput("reset.d_imm", bus_if.d_imm, 32'h0);

        // Three nop cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0000_0010, I_NOP, 1'b0, 1'b0);
            checkComb("nop", 2'd0, 4'd0);
            tick();
            checkBubble("nop");
        end

        // Load-use: lw $t0 then add $t2,$t0,$t0
        applyStimulus(32'h0000_0100, I_LW_T0, 1'b0, 1'b0);
        checkComb("lw", 2'd0, 4'd0);
        tick();
        checkIssued("lw", 32'h0000_0100, I_LW_T0, 5'd8);
        checkOutput("lw.d_rs", 32'(bus_if.d_rs), 32'd9);
        checkOutput("lw.d_is_load", 32'(bus_if.d_is_load), 32'd1);

        applyStimulus(32'h0000_0104, I_ADD_T2, 1'b0, 1'b0);
        checkComb("add_haz", 2'd1, 4'd0);
        tick();
        checkBubble("add_haz");

        applyStimulus(32'h0000_0104, I_ADD_T2, 1'b0, 1'b0);
        checkComb("add_re", 2'd0, 4'd0);
        tick();
        checkIssued("add_re", 32'h0000_0104, I_ADD_T2, 5'd10);
        checkOutput("add_re.d_rs", 32'(bus_if.d_rs), 32'd8);
        checkOutput("add_re.d_rt", 32'(bus_if.d_rt), 32'd8);
        checkOutput("add_re.d_is_load", 32'(bus_if.d_is_load), 32'd0);

        // Jumps
        applyStimulus(32'h0000_0108, I_J, 1'b0, 1'b0);
        checkComb("j", 2'd0, 4'd1);
        tick();
        checkIssued("j", 32'h0000_0108, I_J, 5'd0);

        applyStimulus(32'h0000_010C, I_JAL, 1'b0, 1'b0);
        checkComb("jal", 2'd0, 4'd2);
        tick();
        checkIssued("jal", 32'h0000_010C, I_JAL, 5'd31);

        // Late flush on the would-be hazard cycle
        applyStimulus(32'h0000_0200, I_LW_T0, 1'b0, 1'b0);
        tick();
        checkOutput("lw2.d_is_load", 32'(bus_if.d_is_load), 32'd1);
        applyStimulus(32'h0000_0204, I_ADD_T2, 1'b1, 1'b0);
        checkComb("flush", 2'd0, 4'd0);
        tick();
        checkBubble("flush");
        applyStimulus(32'h0000_0300, I_ADD_T2, 1'b0, 1'b0);
        checkComb("post_flush", 2'd0, 4'd0);
        tick();
        checkIssued("post_flush", 32'h0000_0300, I_ADD_T2, 5'd10);

        // Flush also suppresses an early redirect
        applyStimulus(32'h0000_0304, I_J, 1'b1, 1'b0);
        checkComb("flush_j", 2'd0, 4'd0);
        tick();
        checkBubble("flush_j");

        // Immediate extension
        applyStimulus(32'h0000_0310, I_ORI, 1'b0, 1'b0);
        tick();
        checkIssued("ori", 32'h0000_0310, I_ORI, 5'd8);
        checkOutput("ori.d_imm", bus_if.d_imm, 32'h0000_8000);
        applyStimulus(32'h0000_0314, I_ADDI, 1'b0, 1'b0);
        tick();
        checkOutput("addi.d_imm", bus_if.d_imm, 32'hFFFF_FFFF);

        // Register 0 is never a hazard source
        applyStimulus(32'h0000_0320, I_LW_ZERO, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h0000_0324, I_ADD_ZERO, 1'b0, 1'b0);
        checkComb("zero_reg", 2'd0, 4'd0);
        tick();
        checkIssued("zero_reg", 32'h0000_0324, I_ADD_ZERO, 5'd10);

        // Store reads rt; I-type rt is not a read
        applyStimulus(32'h0000_0330, I_LW_T0, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h0000_0334, I_SW_T0, 1'b0, 1'b0);
        checkComb("sw_haz", 2'd1, 4'd0);
        tick();
        checkBubble("sw_haz");
        applyStimulus(32'h0000_0334, I_SW_T0, 1'b0, 1'b0);
        tick();
        checkIssued("sw", 32'h0000_0334, I_SW_T0, 5'd0);
        checkOutput("sw.d_is_store", 32'(bus_if.d_is_store), 32'd1);
        applyStimulus(32'h0000_0340, I_LW_T0, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h0000_0344, I_ORI_T0, 1'b0, 1'b0);
        checkComb("ori_rt", 2'd0, 4'd0);
        tick();
        checkIssued("ori_rt", 32'h0000_0344, I_ORI_T0, 5'd8);

        // Reset during a hazard cycle
        applyStimulus(32'h0000_0350, I_LW_T0, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h0000_0354, I_ADD_T2, 1'b0, 1'b1);
        checkComb("rst_mid", 2'd0, 4'd0);
        tick();
        checkBubble("rst_mid");
        applyStimulus(32'h0000_0354, I_ADD_T2, 1'b0, 1'b0);
        checkComb("after_rst", 2'd0, 4'd0);
        tick();
        checkIssued("after_rst", 32'h0000_0354, I_ADD_T2, 5'd10);

        // HI/LO read after multiply
        applyStimulus(32'h0000_0400, I_MULT, 1'b0, 1'b0);
        tick();
        checkIssued("mult", 32'h0000_0400, I_MULT, 5'd0);
`ifdef MULDIV_HAZARD_EN
        applyStimulus(32'h0000_0404, I_MFLO, 1'b0, 1'b0);
        checkComb("mflo_haz", 2'd2, 4'd0);
        tick();
        checkBubble("mflo_haz");
        applyStimulus(32'h0000_0404, I_MFLO, 1'b0, 1'b0);
        checkComb("mflo_wait", 2'd0, 4'd0);
        tick();
        checkBubble("mflo_wait");
        applyStimulus(32'h0000_0404, I_MFLO, 1'b0, 1'b0);
        checkComb("mflo_go", 2'd0, 4'd0);
        tick();
        checkIssued("mflo_go", 32'h0000_0404, I_MFLO, 5'd10);
`else
        applyStimulus(32'h0000_0404, I_MFLO, 1'b0, 1'b0);
        checkComb("mflo", 2'd0, 4'd0);
        tick();
        checkIssued("mflo", 32'h0000_0404, I_MFLO, 5'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
